mem_output_sched: RTL and testbench
===================================

MEM_OUTPUT_SCHED -- requirements
Module: mem_output_sched

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall  in  1  global pipeline freeze; batch_size  in  9  number of reads in the batch, 0..511.
REQ-004 SHALL have ports: ret_valid  in  1; ret_read_num  in  10; ret  in  32  per-read return code.
REQ-005 SHALL have ports: mem_size_valid  in  1; mem_size_read_num  in  10; mem_size  in  7  per-read SMEM count.
REQ-006 SHALL have ports: mem_rd_en  out  1; mem_rd_read_num  out  10; mem_rd_addr  out  7; mem_rd_q  in  256  mem-queue read data, valid 1 cycle after mem_rd_en.
REQ-007 SHALL have ports: output_request  out  1; output_permit  in  1; output_data  out  512; output_valid  out  1; output_finish  out  1.

Function
REQ-008 SHALL keep per-read tables ret_tab[512]x32, size_tab[512]x7 and done_map[512]x1, written on ret_valid or mem_size_valid.
REQ-009 SHALL ignore ret/mem_size updates whose read_num >= batch_size.
REQ-010 SHALL set done_map[n] on mem_size_valid for read n and increment done_cnt only if done_map[n] was 0, so duplicates count once.
REQ-011 SHALL use FSM states IDLE, COLLECT, REQ, HDR, RD, DONE.
REQ-012 IDLE->COLLECT SHALL occur when batch_size != 0; with batch_size = 0 the FSM SHALL stay in IDLE and issue no request.
REQ-013 COLLECT->REQ SHALL occur in the cycle after done_cnt == batch_size.
REQ-014 In REQ, output_request SHALL be 1; on output_permit = 1 the FSM SHALL move to HDR with cur = 0.
REQ-015 output_permit SHALL be sampled only in REQ; deasserting it mid-stream SHALL have no effect.
REQ-016 HDR SHALL emit one beat with output_valid = 1 and format [31:0] ret_tab[cur], [38:32] size_tab[cur], [48:39] cur, all other bits 0.
REQ-017 After HDR, if size_tab[cur] = 0 the FSM SHALL advance to the next read; otherwise it SHALL enter RD.
REQ-018 RD SHALL issue mem_rd_en with mem_rd_read_num = cur and mem_rd_addr = 0..size-1, one address per unstalled cycle.
REQ-019 RD SHALL pack entries two per beat: entry 2k in [255:0], entry 2k+1 in [511:256], and the upper half zero for an odd final entry.
REQ-020 Each data beat SHALL assert output_valid exactly once, one cycle after the read of its upper entry, or of the odd last entry.
REQ-021 After the last beat of read batch_size-1 the FSM SHALL enter DONE.
REQ-022 DONE SHALL pulse output_finish for one cycle, clear done_map and done_cnt, then return to IDLE.
REQ-023 While stall = 1, FSM state, counters, addresses and the pack register SHALL hold; mem_rd_en = 0 and output_valid = 0.
REQ-024 Read data returning during the first stall cycle SHALL be captured and not lost.
REQ-025 On release of stall, output SHALL resume with the same beat that was pending.
REQ-026 Updates arriving during HDR/RD SHALL still be written to the tables but SHALL NOT alter the batch in progress.
REQ-027 Address arithmetic SHALL be 7-bit and SHALL never wrap, because size <= 127.

Reset
REQ-028 reset SHALL force IDLE and clear done_map, done_cnt, cur and the pack register.
REQ-029 After reset, all outputs SHALL be 0 (output_request, output_valid, output_finish, mem_rd_en, output_data, mem_rd_*).
REQ-030 reset asserted mid-stream SHALL abort the stream without emitting output_finish.

Structure
REQ-031 Beat field offsets, the state encoding, MAX_READS = 512 and the entry width of 256 SHALL live in the shared smem_pkg package.
REQ-032 The table storage SHALL be one sub-module, read_info_tab: dual-port, one write port and one combinational read port.

Verification
REQ-033 batch_size = 3; mem_size 1, 2, 3 and ret 1, 2, 3 arrive in order; permit after request. Required: beats H0, D{e0,0}, H1, D{e0,e1}, H2, D{e0,e1}, D{e2,0}, then output_finish.
REQ-034 batch_size = 2; mem_size for read 1 arrives before read 0, with a duplicate for read 1. Required: output_request only after read 0's mem_size arrives.
REQ-035 batch_size = 2; size_tab = {0, 2}. Required: H0 alone, then H1 followed by one data beat, with no mem_rd_en issued for read 0.
REQ-036 Assert stall for 2 cycles mid-RD. Required: no output_valid during the stall and an identical beat sequence to the unstalled run.
REQ-037 Assert reset during HDR of read 1. Required: outputs 0 next cycle, no output_finish, and a new batch completes normally.
REQ-038 Hold output_permit = 0 for 10 cycles. Required: output_request stays 1 and no beats are emitted until permit.

Source files
------------

// File: rtl/smem_pkg.sv
// smem_pkg: shared constants, beat layout and FSM
// encoding for the SMEM output scheduler.
package smem_pkg;

  localparam int MAX_READS = 512;
  localparam int RN_W      = 9;
  localparam int ENTRY_W   = 256;
  localparam int BEAT_W    = 512;
  localparam int RET_W     = 32;
  localparam int SIZE_W    = 7;
  localparam int NUM_W     = 10;

  localparam int HDR_RET_LSB  = 0;
  localparam int HDR_SIZE_LSB = 32;
  localparam int HDR_NUM_LSB  = 39;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    REQ     = 3'd2,
    HDR     = 3'd3,
    RD      = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic logic [BEAT_W-1:0] mk_hdr(
    input logic [RET_W-1:0]  r,
    input logic [SIZE_W-1:0] s,
    input logic [NUM_W-1:0]  n
  );
    logic [BEAT_W-1:0] b;
    b = '0;
    b[HDR_RET_LSB  +: RET_W]  = r;
    b[HDR_SIZE_LSB +: SIZE_W] = s;
    b[HDR_NUM_LSB  +: NUM_W]  = n;
    return b;
  endfunction

endpackage

// File: rtl/read_info_tab.sv
// read_info_tab: per-read table, one write port
// and one combinational read port.
module read_info_tab
  import smem_pkg::*;
#(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [RN_W-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic [RN_W-1:0] raddr,
  output logic [W-1:0]    rdata
);

  logic [W-1:0] mem [MAX_READS];

  // write port; contents are not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_output_sched.sv
// mem_output_sched: collects per-read results, then
// streams header and packed SMEM beats per read.
module mem_output_sched
  import smem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [8:0]         batch_size,
  input  logic               ret_valid,
  input  logic [9:0]         ret_read_num,
  input  logic [31:0]        ret,
  input  logic               mem_size_valid,
  input  logic [9:0]         mem_size_read_num,
  input  logic [6:0]         mem_size,
  output logic               mem_rd_en,
  output logic [9:0]         mem_rd_read_num,
  output logic [6:0]         mem_rd_addr,
  input  logic [255:0]       mem_rd_q,
  output logic               output_request,
  input  logic               output_permit,
  output logic [511:0]       output_data,
  output logic               output_valid,
  output logic               output_finish
);

  state_t state, state_nx;

  logic [RN_W-1:0]      cur, cur_nx;
  logic [SIZE_W-1:0]    addr, addr_nx;
  logic [SIZE_W-1:0]    cur_size, cur_size_nx;
  logic [RN_W-1:0]      done_cnt;
  logic [MAX_READS-1:0] done_map;
  logic                 pend, pend_odd, pend_last;
  logic [ENTRY_W-1:0]   pack_lo, hold, dq;
  logic                 hold_vld;
  logic                 ret_we, size_we;
  logic                 track_en, new_done;
  logic                 last_rd, rd_issue;
  logic [RET_W-1:0]     ret_rd;
  logic [SIZE_W-1:0]    size_rd;

  assign ret_we  = ret_valid
                 && (ret_read_num < {1'b0, batch_size});
  assign size_we = mem_size_valid
                 && (mem_size_read_num < {1'b0, batch_size});

  read_info_tab #(.W(RET_W)) u_ret_tab (
    .clk   (clk),
    .we    (ret_we),
    .waddr (ret_read_num[RN_W-1:0]),
    .wdata (ret),
    .raddr (cur),
    .rdata (ret_rd)
  );

  read_info_tab #(.W(SIZE_W)) u_size_tab (
    .clk   (clk),
    .we    (size_we),
    .waddr (mem_size_read_num[RN_W-1:0]),
    .wdata (mem_size),
    .raddr (cur),
    .rdata (size_rd)
  );

  assign track_en = (state == IDLE)
                 || (state == COLLECT)
                 || (state == REQ);
  assign new_done = size_we && track_en
                 && !done_map[mem_size_read_num[RN_W-1:0]];
  assign last_rd  = ({1'b0, cur} + 10'd1)
                 == {1'b0, batch_size};
  assign rd_issue = (state == RD) && (addr != cur_size);
  assign dq       = hold_vld ? hold : mem_rd_q;

  assign mem_rd_read_num = mem_rd_en ? {1'b0, cur} : '0;
  assign mem_rd_addr     = mem_rd_en ? addr : '0;

  // next-state, beat formatting and read issue
  always_comb begin
    state_nx       = state;
    cur_nx         = cur;
    addr_nx        = addr;
    cur_size_nx    = cur_size;
    mem_rd_en      = 1'b0;
    output_request = 1'b0;
    output_valid   = 1'b0;
    output_finish  = 1'b0;
    output_data    = '0;
    unique case (state)
      IDLE: begin
        if (!stall && batch_size != '0)
          state_nx = COLLECT;
      end
      COLLECT: begin
        if (!stall && done_cnt == batch_size)
          state_nx = REQ;
      end
      REQ: begin
        output_request = 1'b1;
        if (!stall && output_permit) begin
          state_nx = HDR;
          cur_nx   = '0;
        end
      end
      HDR: begin
        if (!stall) begin
          output_valid = 1'b1;
          output_data  = mk_hdr(ret_rd, size_rd,
                                {1'b0, cur});
          cur_size_nx  = size_rd;
          addr_nx      = '0;
          if (size_rd != '0)
            state_nx = RD;
          else if (last_rd)
            state_nx = DONE;
          else
            cur_nx = cur + 1'b1;
        end
      end
      RD: begin
        if (!stall) begin
          mem_rd_en = rd_issue;
          if (pend && pend_odd) begin
            output_valid = 1'b1;
            output_data  = {dq, pack_lo};
          end else if (pend && pend_last) begin
            output_valid = 1'b1;
            output_data  = {{ENTRY_W{1'b0}}, dq};
          end
          if (rd_issue)
            addr_nx = addr + 1'b1;
          else if (last_rd)
            state_nx = DONE;
          else begin
            state_nx = HDR;
            cur_nx   = cur + 1'b1;
          end
        end
      end
      DONE: begin
        if (!stall) begin
          output_finish = 1'b1;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // sequencing state and the read-data pack pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      addr      <= '0;
      cur_size  <= '0;
      pend      <= 1'b0;
      pend_odd  <= 1'b0;
      pend_last <= 1'b0;
      pack_lo   <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
    end else if (stall) begin
      if (pend && !hold_vld) begin
        hold     <= mem_rd_q;
        hold_vld <= 1'b1;
      end
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      addr      <= addr_nx;
      cur_size  <= cur_size_nx;
      pend      <= rd_issue;
      pend_odd  <= addr[0];
      pend_last <= (addr + 1'b1) == cur_size;
      hold_vld  <= 1'b0;
      if (pend && !pend_odd && !pend_last)
        pack_lo <= dq;
    end
  end

  // completion tracking; duplicates count once
  always_ff @(posedge clk) begin
    if (reset) begin
      done_map <= '0;
      done_cnt <= '0;
    end else if (state == DONE && !stall) begin
      done_map <= '0;
      done_cnt <= '0;
    end else if (new_done) begin
      done_map[mem_size_read_num[RN_W-1:0]] <= 1'b1;
      done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_output_sched.sv
// tb_mem_output_sched: directed checks of the
// SMEM output scheduler beat stream.
module tb_mem_output_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic [8:0]   batch_size;
  logic         ret_valid;
  logic [9:0]   ret_read_num;
  logic [31:0]  ret;
  logic         mem_size_valid;
  logic [9:0]   mem_size_read_num;
  logic [6:0]   mem_size;
  logic         mem_rd_en;
  logic [9:0]   mem_rd_read_num;
  logic [6:0]   mem_rd_addr;
  logic [255:0] mem_rd_q;
  logic         output_request;
  logic         output_permit;
  logic [511:0] output_data;
  logic         output_valid;
  logic         output_finish;

  always #5 clk = ~clk;

  mem_output_sched dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .batch_size        (batch_size),
    .ret_valid         (ret_valid),
    .ret_read_num      (ret_read_num),
    .ret               (ret),
    .mem_size_valid    (mem_size_valid),
    .mem_size_read_num (mem_size_read_num),
    .mem_size          (mem_size),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_read_num   (mem_rd_read_num),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_q          (mem_rd_q),
    .output_request    (output_request),
    .output_permit     (output_permit),
    .output_data       (output_data),
    .output_valid      (output_valid),
    .output_finish     (output_finish)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int fin_cnt  = 0;
  int rd_cnt   = 0;
  int rd0_cnt  = 0;
  logic [511:0] beats[$];
  logic [511:0] exp_q[$];

  function automatic logic [255:0] ent(
    input logic [9:0] n, input logic [6:0] a);
    return {8'hEE, 216'd0, 6'd0, n, 9'd0, a};
  endfunction

  function automatic logic [511:0] hdr(
    input logic [31:0] r, input logic [6:0] s,
    input logic [9:0] n);
    logic [511:0] b;
    b = '0;
    b[31:0]  = r;
    b[38:32] = s;
    b[48:39] = n;
    return b;
  endfunction

  function automatic logic [511:0] dat(
    input logic [255:0] lo, input logic [255:0] hi);
    return {hi, lo};
  endfunction

  // memory queue model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rd_q <= ent(mem_rd_read_num, mem_rd_addr);
    else
      mem_rd_q <= {8{32'hDEAD_BEEF}};
  end

  // output monitor
  always @(negedge clk) begin
    if (output_valid) beats.push_back(output_data);
    if (output_finish) fin_cnt++;
    if (mem_rd_en) begin
      rd_cnt++;
      if (mem_rd_read_num == 10'd0) rd0_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic ms(input int n, input int s);
    mem_size_valid    = 1'b1;
    mem_size_read_num = 10'(n);
    mem_size          = 7'(s);
    tick();
    mem_size_valid    = 1'b0;
  endtask

  task automatic rt(input int n, input int r);
    ret_valid    = 1'b1;
    ret_read_num = 10'(n);
    ret          = 32'(r);
    tick();
    ret_valid    = 1'b0;
  endtask

  task automatic wait_fin(input string tag,
                          input int budget);
    int f0;
    f0 = fin_cnt;
    for (int i = 0; i < budget; i++) begin
      if (fin_cnt > f0) break;
      tick();
    end
    repeat (3) tick();
    chk(tag, 512'(fin_cnt - f0), 512'd1);
  endtask

  task automatic check_beats(input string tag);
    logic [511:0] obs;
    chk({tag, "_count"}, 512'(beats.size()),
        512'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < beats.size()) ? beats[i] : '0;
      chk($sformatf("%s_beat%0d", tag, i),
          obs, exp_q[i]);
    end
  endtask

  int f0;
  int r0;
  int rt0;

  initial begin
    reset             = 1'b1;
    stall             = 1'b0;
    batch_size        = '0;
    ret_valid         = 1'b0;
    ret_read_num      = '0;
    ret               = '0;
    mem_size_valid    = 1'b0;
    mem_size_read_num = '0;
    mem_size          = '0;
    output_permit     = 1'b0;
    tick();
    tick();
    chk("rst_request", 512'(output_request), 512'd0);
    chk("rst_valid", 512'(output_valid), 512'd0);
    chk("rst_finish", 512'(output_finish), 512'd0);
    chk("rst_rd_en", 512'(mem_rd_en), 512'd0);
    chk("rst_data", output_data, 512'd0);
    chk("rst_rd_num", 512'(mem_rd_read_num), 512'd0);
    chk("rst_rd_addr", 512'(mem_rd_addr), 512'd0);
    reset = 1'b0;

    // empty batch never requests
    ms(0, 1);
    repeat (5) tick();
    chk("zero_batch_req", 512'(output_request), 512'd0);

    // basic three-read batch
    beats.delete();
    batch_size    = 9'd3;
    output_permit = 1'b1;
    rt(0, 1);
    ms(0, 1);
    rt(1, 2);
    ms(1, 2);
    repeat (2) tick();
    chk("a_no_req_early", 512'(output_request), 512'd0);
    rt(2, 3);
    ms(2, 3);
    wait_fin("a_finish", 300);
    exp_q = '{hdr(1, 1, 0), dat(ent(0, 0), '0),
              hdr(2, 2, 1), dat(ent(1, 0), ent(1, 1)),
              hdr(3, 3, 2), dat(ent(2, 0), ent(2, 1)),
              dat(ent(2, 2), '0)};
    check_beats("a");

    // same batch with a two-cycle stall mid-read
    beats.delete();
    ms(0, 1);
    ms(1, 2);
    ms(2, 3);
    for (int i = 0; i < 100; i++) begin
      if (mem_rd_en && mem_rd_read_num == 10'd2
          && mem_rd_addr == 7'd2) break;
      tick();
    end
    chk("s_found",
        512'(mem_rd_en && mem_rd_read_num == 10'd2
             && mem_rd_addr == 7'd2), 512'd1);
    stall = 1'b1;
    #1;
    chk("s_valid0_c0", 512'(output_valid), 512'd0);
    chk("s_rd_en0_c0", 512'(mem_rd_en), 512'd0);
    tick();
    chk("s_valid0_c1", 512'(output_valid), 512'd0);
    chk("s_rd_en0_c1", 512'(mem_rd_en), 512'd0);
    tick();
    stall = 1'b0;
    wait_fin("s_finish", 300);
    check_beats("s");

    // out-of-order sizes with a duplicate, held permit
    beats.delete();
    batch_size    = 9'd2;
    output_permit = 1'b0;
    rt(0, 10);
    rt(1, 11);
    ms(1, 1);
    ms(1, 1);
    repeat (3) tick();
    chk("b_dup_no_req", 512'(output_request), 512'd0);
    ms(0, 1);
    for (int i = 0; i < 20; i++) begin
      if (output_request) break;
      tick();
    end
    chk("b_req_seen", 512'(output_request), 512'd1);
    repeat (10) tick();
    chk("b_req_held", 512'(output_request), 512'd1);
    chk("b_no_beats", 512'(beats.size()), 512'd0);
    output_permit = 1'b1;
    wait_fin("b_finish", 200);
    exp_q = '{hdr(10, 1, 0), dat(ent(0, 0), '0),
              hdr(11, 1, 1), dat(ent(1, 0), '0)};
    check_beats("b");

    // zero-size read, plus an out-of-range update
    beats.delete();
    r0  = rd0_cnt;
    rt0 = rd_cnt;
    rt(0, 20);
    rt(1, 21);
    ms(5, 3);
    ms(0, 0);
    repeat (3) tick();
    chk("c_ignore_no_req", 512'(output_request), 512'd0);
    ms(1, 2);
    wait_fin("c_finish", 200);
    exp_q = '{hdr(20, 0, 0), hdr(21, 2, 1),
              dat(ent(1, 0), ent(1, 1))};
    check_beats("c");
    chk("c_rd0_none", 512'(rd0_cnt - r0), 512'd0);
    chk("c_rd_total", 512'(rd_cnt - rt0), 512'd2);

    // reset during the header of read 1
    beats.delete();
    rt(0, 30);
    rt(1, 31);
    ms(0, 1);
    ms(1, 1);
    for (int i = 0; i < 100; i++) begin
      if (output_valid && output_data[48:39] == 10'd1
          && output_data[255:248] == 8'd0) break;
      tick();
    end
    chk("d_hdr1_found",
        512'(output_valid && output_data[48:39] == 10'd1),
        512'd1);
    f0    = fin_cnt;
    reset = 1'b1;
    tick();
    chk("d_rst_request", 512'(output_request), 512'd0);
    chk("d_rst_valid", 512'(output_valid), 512'd0);
    chk("d_rst_finish", 512'(output_finish), 512'd0);
    chk("d_rst_rd_en", 512'(mem_rd_en), 512'd0);
    chk("d_rst_data", output_data, 512'd0);
    reset = 1'b0;
    repeat (20) tick();
    chk("d_no_finish", 512'(fin_cnt - f0), 512'd0);
    chk("d_no_req", 512'(output_request), 512'd0);
    beats.delete();
    ms(0, 1);
    ms(1, 1);
    wait_fin("d_finish", 200);
    exp_q = '{hdr(30, 1, 0), dat(ent(0, 0), '0),
              hdr(31, 1, 1), dat(ent(1, 0), '0)};
    check_beats("d");

    batch_size = '0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
